delay_ctrl: RTL

Front-end controller for the frame delayer. It registers the incoming pixel stream and forwards it to the delayer. It validates each frame's geometry and gates the delayer's write and read enables so DDR reads only start after enough well-formed frames have been stored. It also selects live or delayed pixels for the final video output.

---
 rtl/delay_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/delay_ctrl.sv
// rtl/delay_ctrl.sv - frame delayer front-end: input register, geometry check, wen/ren gating, output mux
// Enables change only at frame start so the delayer never sees a mode change mid-frame.
module delay_ctrl #(
   parameter int H_WIDTH     = 1920,
   parameter int V_HEIGHT    = 1080,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        vs_i,
   input  logic        de_i,
   input  logic [23:0] data_i,
   output logic        vs_o,
   output logic        de_o,
   output logic [23:0] data_o,
   output logic        wen_o,
   output logic        ren_o,
   input  logic [23:0] dly_data_i,
   output logic        vid_vs_o,
   output logic        vid_de_o,
   output logic [23:0] vid_data_o,
   output logic        locked_o,
   output logic        err_o
);

   localparam int FRAME_PIX = H_WIDTH * V_HEIGHT;
   localparam int PIX_W     = $clog2(FRAME_PIX + 2);
   localparam int LINE_W    = $clog2(V_HEIGHT + 2);
   localparam int GOOD_W    = $clog2(LOCK_FRAMES + 1);

   localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(FRAME_PIX);
   localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(FRAME_PIX + 1);
   localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_HEIGHT);
   localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_HEIGHT + 1);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
   logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
   logic                vs_q, de_q;
   logic [23:0]         data_q;
   logic                wen_q, ren_q, locked_q, err_q, err_d;
   logic                vid_vs_q, vid_de_q;
   logic [23:0]         vid_data_q;

   logic fs;
   logic frame_good;

   assign fs         = vs_i & ~vs_q;
   assign frame_good = (pix_cnt_q == PIX_FULL) && (line_cnt_q == LINE_FULL);

   // Counters reload on fs so a pixel coincident with vsync belongs to the new frame.
   always_comb begin
      pix_cnt_d  = pix_cnt_q;
      line_cnt_d = line_cnt_q;
      if (fs) begin
         pix_cnt_d  = de_i ? PIX_W'(1) : '0;
         line_cnt_d = '0;
      end else begin
         if (de_i && (pix_cnt_q != PIX_SAT)) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
         end
         if (de_q && !de_i && (line_cnt_q != LINE_SAT)) begin
            line_cnt_d = line_cnt_q + LINE_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      err_d      = 1'b0;
      if (fs) begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  state_d    = ST_FILL;
                  good_cnt_d = '0;
               end
            end
            ST_FILL: begin
               if (!enable_i) begin
                  state_d = ST_IDLE;
               end else if (!frame_good) begin
                  good_cnt_d = '0;
               end else if ((good_cnt_q + GOOD_W'(1)) == GOOD_LOCK) begin
                  state_d = ST_RUN;
               end else begin
                  good_cnt_d = good_cnt_q + GOOD_W'(1);
               end
            end
            ST_RUN: begin
               if (!enable_i) begin
                  state_d = ST_IDLE;
               end else if (!frame_good) begin
                  state_d    = ST_FILL;
                  good_cnt_d = '0;
                  err_d      = 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               good_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         good_cnt_q <= '0;
         pix_cnt_q  <= '0;
         line_cnt_q <= '0;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         data_q     <= '0;
         wen_q      <= 1'b0;
         ren_q      <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         vid_vs_q   <= 1'b0;
         vid_de_q   <= 1'b0;
         vid_data_q <= '0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         line_cnt_q <= line_cnt_d;
         vs_q       <= vs_i;
         de_q       <= de_i;
         data_q     <= data_i;
         wen_q      <= (state_d != ST_IDLE);
         ren_q      <= (state_d == ST_RUN);
         locked_q   <= (state_d == ST_RUN);
         err_q      <= err_d;
         vid_vs_q   <= vs_q;
         vid_de_q   <= de_q;
         vid_data_q <= de_q ? (ren_q ? dly_data_i : data_q) : 24'h0;
      end
   end

   assign vs_o       = vs_q;
   assign de_o       = de_q;
   assign data_o     = data_q;
   assign wen_o      = wen_q;
   assign ren_o      = ren_q;
   assign locked_o   = locked_q;
   assign err_o      = err_q;
   assign vid_vs_o   = vid_vs_q;
   assign vid_de_o   = vid_de_q;
   assign vid_data_o = vid_data_q;

endmodule
